// File: rtl/laser500_keymatrix.sv
// PS/2 key events -> Laser 500 8x7 key matrix, plus F12 reset stretch and Caps Lock latch.
// Matrix bit updates on the third clock edge counting the one that sees the toggle; one pending event is buffered while busy (newest wins).
module laser500_keymatrix #(
    parameter int RESET_PULSE = 4800,
    parameter int ROWS        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  row_sel,
    output logic [6:0]  kd,
    output logic        caps_led,
    output logic        rst_req,
    output logic        busy
);

    localparam int CW = $clog2(RESET_PULSE + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, APPLY} state_t;

    state_t                 state;
    logic                   hist;
    logic                   hist_vld;
    logic                   evt;
    logic [9:0]             cur;
    logic [9:0]             pend;
    logic                   pend_vld;
    logic                   km_vld;
    logic [2:0]             km_row;
    logic [2:0]             km_col;
    logic                   km_f12;
    logic                   km_caps;
    logic [ROWS-1:0][6:0]   matrix;
    logic [CW-1:0]          rst_cnt;
    logic [6:0]             hit;

    function automatic logic [6:0] ke(input int r, input int c);
        return {1'b1, 3'(r), 3'(c)};
    endfunction

    // Key is {ext, code}; result is {valid, row, col}.
    function automatic logic [6:0] keymap(input logic [8:0] key);
        logic [6:0] e;
        e = 7'h00;
        case (key)
            9'h015: e = ke(0, 0);  9'h01D: e = ke(0, 1);  9'h024: e = ke(0, 2);
            9'h02D: e = ke(0, 3);  9'h02C: e = ke(0, 4);
            9'h014, 9'h114: e = ke(0, 5);
            9'h012, 9'h059: e = ke(0, 6);
            9'h01C: e = ke(1, 0);  9'h01B: e = ke(1, 1);  9'h023: e = ke(1, 2);
            9'h02B: e = ke(1, 3);  9'h034: e = ke(1, 4);
            9'h01A: e = ke(2, 0);  9'h022: e = ke(2, 1);  9'h021: e = ke(2, 2);
            9'h02A: e = ke(2, 3);  9'h032: e = ke(2, 4);
            9'h016: e = ke(3, 0);  9'h01E: e = ke(3, 1);  9'h026: e = ke(3, 2);
            9'h025: e = ke(3, 3);  9'h02E: e = ke(3, 4);
            9'h045: e = ke(4, 0);  9'h046: e = ke(4, 1);  9'h03E: e = ke(4, 2);
            9'h03D: e = ke(4, 3);  9'h036: e = ke(4, 4);
            9'h04D: e = ke(5, 0);  9'h044: e = ke(5, 1);  9'h043: e = ke(5, 2);
            9'h03C: e = ke(5, 3);  9'h035: e = ke(5, 4);
            9'h04C: e = ke(6, 0);  9'h04B: e = ke(6, 1);  9'h05A: e = ke(6, 2);
            9'h042: e = ke(6, 3);  9'h03B: e = ke(6, 4);  9'h033: e = ke(6, 5);
            9'h03A: e = ke(7, 0);  9'h16B: e = ke(7, 1);  9'h174: e = ke(7, 2);
            9'h175: e = ke(7, 3);  9'h029: e = ke(7, 4);  9'h031: e = ke(7, 5);
            9'h172: e = ke(7, 6);
            default: e = 7'h00;
        endcase
        return e;
    endfunction

    // History only becomes valid one clock after reset, so a held toggle level is never an event.
    assign evt  = hist_vld && (ps2_key[10] != hist);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            hist     <= 1'b0;
            hist_vld <= 1'b0;
            cur      <= '0;
            pend     <= '0;
            pend_vld <= 1'b0;
            km_vld   <= 1'b0;
            km_row   <= '0;
            km_col   <= '0;
            km_f12   <= 1'b0;
            km_caps  <= 1'b0;
            matrix   <= '0;
            caps_led <= 1'b0;
            rst_req  <= 1'b0;
            rst_cnt  <= '0;
        end else begin
            hist     <= ps2_key[10];
            hist_vld <= 1'b1;
            case (state)
                IDLE: begin
                    if (evt) begin
                        cur   <= ps2_key[9:0];
                        state <= LOOKUP;
                    end else if (pend_vld) begin
                        cur      <= pend;
                        pend_vld <= 1'b0;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    {km_vld, km_row, km_col} <= keymap(cur[8:0]);
                    km_f12  <= (cur[8:0] == 9'h007);
                    km_caps <= (cur[8:0] == 9'h058);
                    state   <= APPLY;
                    if (evt) begin
                        pend     <= ps2_key[9:0];
                        pend_vld <= 1'b1;
                    end
                end
                APPLY: begin
                    if (km_vld)
                        matrix[km_row][km_col] <= cur[9];
                    if (km_caps && cur[9])
                        caps_led <= ~caps_led;
                    // A toggle seen right now would overwrite the pending slot anyway, so take it directly.
                    if (evt) begin
                        cur      <= ps2_key[9:0];
                        pend_vld <= 1'b0;
                        state    <= LOOKUP;
                    end else if (pend_vld) begin
                        cur      <= pend;
                        pend_vld <= 1'b0;
                        state    <= LOOKUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (state == APPLY && km_f12 && cur[9]) begin
                rst_req <= 1'b1;
                rst_cnt <= CW'(RESET_PULSE - 1);
            end else if (rst_req) begin
                if (rst_cnt == '0)
                    rst_req <= 1'b0;
                else
                    rst_cnt <= rst_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        hit = '0;
        for (int r = 0; r < ROWS; r++)
            if (!row_sel[r])
                hit = hit | matrix[r];
    end

    assign kd = ~hit;

endmodule

// File: tb/tb_laser500_keymatrix.sv
// Directed bench for laser500_keymatrix: key-chart model plus hand-computed timing and literal checks.
module tb_laser500_keymatrix;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [7:0]  row_sel;
    logic [6:0]  kd;
    logic        caps_led;
    logic        rst_req;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    int   hi_cnt = 0;
    int   hi_base;
    bit   quiet = 1'b0;

    logic [6:0] exp_mat [8];
    bit         exp_caps;

    localparam logic [7:0] PATS [11] = '{8'hFF, 8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF,
                                         8'hDF, 8'hBF, 8'h7F, 8'h00, 8'hF9};

    always #5 clk = ~clk;

    laser500_keymatrix dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .row_sel  (row_sel),
        .kd       (kd),
        .caps_led (caps_led),
        .rst_req  (rst_req),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Normative chart positions as row*8+col; -1 for anything the bench treats as unmapped.
    function automatic int bmap(input logic ext, input logic [7:0] code);
        case ({ext, code})
            9'h01C:         return 8;
            9'h01A:         return 16;
            9'h05A:         return 50;
            9'h029:         return 60;
            9'h012, 9'h059: return 6;
            9'h16B:         return 57;
            default:        return -1;
        endcase
    endfunction

    function automatic logic [6:0] exp_kd(input logic [7:0] sel);
        logic [6:0] o;
        o = 7'h00;
        for (int r = 0; r < 8; r++)
            if (!sel[r])
                o = o | exp_mat[r];
        return ~o;
    endfunction

    task automatic model(input logic p, input logic e, input logic [7:0] c);
        int m;
        if (!e && c == 8'h58) begin
            if (p)
                exp_caps = !exp_caps;
        end else begin
            m = bmap(e, c);
            if (m >= 0)
                exp_mat[m / 8][m % 8] = p;
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < 8; r++)
            exp_mat[r] = 7'h00;
        exp_caps = 1'b0;
    endtask

    always @(negedge clk) begin
        if (quiet && reset_n) begin
            chk("kd_model", 32'(kd), 32'(exp_kd(row_sel)));
            chk("caps_model", 32'(caps_led), 32'(exp_caps));
            chk("busy_idle", 32'(busy), 32'h0);
        end
    end

    always @(negedge clk)
        if (rst_req === 1'b1)
            hi_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic e, input logic [7:0] c);
        ps2_key = {~ps2_key[10], p, e, c};
    endtask

    task automatic send(input logic p, input logic e, input logic [7:0] c);
        drive(p, e, c);
        model(p, e, c);
        repeat (4) step();
    endtask

    task automatic sweep();
        quiet = 1'b1;
        for (int i = 0; i < 11; i++) begin
            row_sel = PATS[i];
            step();
        end
        quiet = 1'b0;
    endtask

    task automatic kd_at(input string name, input logic [7:0] sel, input logic [6:0] exp);
        row_sel = sel;
        @(negedge clk);
        chk(name, 32'(kd), 32'(exp));
        step();
    endtask

    task automatic wait_rst(input logic val, input int max, input string name);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (rst_req === val)
                break;
        end
        chk(name, 32'(rst_req), 32'(val));
        step();
    endtask

    task automatic busy_seq(input string name, input int ones, input int total);
        for (int i = 0; i < total; i++) begin
            @(negedge clk);
            chk(name, 32'(busy), (i < ones) ? 32'h1 : 32'h0);
        end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_model();
        reset_n = 1'b0;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
        row_sel = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_kd", 32'(kd), 32'h7F);
        chk("reset_caps", 32'(caps_led), 32'h0);
        chk("reset_rst_req", 32'(rst_req), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        step();
        reset_n = 1'b1;
        busy_seq("post_reset_no_event", 0, 3);
        sweep();

        // 1: press A, exact latency, row isolation, release
        row_sel = 8'hFD;
        drive(1'b1, 1'b0, 8'h1C);
        model(1'b1, 1'b0, 8'h1C);
        @(negedge clk); chk("t1_busy_before", 32'(busy), 32'h0);
        @(negedge clk); chk("t1_busy_lookup", 32'(busy), 32'h1);
        @(negedge clk); chk("t1_kd_in_apply", 32'(kd), 32'h7F);
        @(negedge clk); chk("t1_kd_applied", 32'(kd), 32'h7E);
        chk("t1_busy_after", 32'(busy), 32'h0);
        step();
        kd_at("t1_other_row", 8'hFB, 7'h7F);
        sweep();
        send(1'b0, 1'b0, 8'h1C);
        kd_at("t1_release", 8'hFD, 7'h7F);

        // 2: wire-AND of two rows, shared shift bit
        send(1'b1, 1'b0, 8'h1C);
        send(1'b1, 1'b0, 8'h1A);
        kd_at("t2_rows_1_2", 8'hF9, 7'h7E);
        send(1'b1, 1'b0, 8'h12);
        send(1'b1, 1'b0, 8'h59);
        send(1'b0, 1'b0, 8'h59);
        kd_at("t2_shift_cleared", 8'hFE, 7'h7F);
        sweep();

        // 3: two and three back-to-back toggles
        drive(1'b1, 1'b0, 8'h29);
        model(1'b1, 1'b0, 8'h29);
        step();
        drive(1'b1, 1'b0, 8'h5A);
        model(1'b1, 1'b0, 8'h5A);
        busy_seq("t3_busy_two", 4, 5);
        kd_at("t3_space", 8'h7F, 7'h6F);
        kd_at("t3_return", 8'hBF, 7'h7B);
        sweep();
        drive(1'b0, 1'b0, 8'h29);
        model(1'b0, 1'b0, 8'h29);
        step();
        drive(1'b0, 1'b0, 8'h5A);
        step();
        drive(1'b1, 1'b1, 8'h6B);
        model(1'b1, 1'b1, 8'h6B);
        busy_seq("t3_busy_three", 3, 4);
        kd_at("t3_row7", 8'h7F, 7'h7D);
        kd_at("t3_return_kept", 8'hBF, 7'h7B);
        sweep();

        // 4: F12 pulse width and re-press reload
        hi_base = hi_cnt;
        drive(1'b1, 1'b0, 8'h07);
        wait_rst(1'b1, 10, "t4_rise");
        wait_rst(1'b0, 6000, "t4_fall");
        chk("t4_width", 32'(hi_cnt - hi_base), 32'd4800);
        hi_base = hi_cnt;
        drive(1'b1, 1'b0, 8'h07);
        repeat (2000) step();
        drive(1'b1, 1'b0, 8'h07);
        wait_rst(1'b0, 8000, "t4_repress_fall");
        chk("t4_repress_width", 32'(hi_cnt - hi_base), 32'd6800);
        send(1'b0, 1'b0, 8'h07);
        @(negedge clk); chk("t4_release_ignored", 32'(rst_req), 32'h0);
        step();
        sweep();

        // 5: Caps Lock latch, unmapped codes
        send(1'b1, 1'b0, 8'h58);
        @(negedge clk); chk("t5_caps_on", 32'(caps_led), 32'h1);
        step();
        send(1'b0, 1'b0, 8'h58);
        send(1'b1, 1'b0, 8'h58);
        send(1'b0, 1'b0, 8'h58);
        @(negedge clk); chk("t5_caps_off", 32'(caps_led), 32'h0);
        step();
        send(1'b1, 1'b0, 8'h76);
        sweep();
        send(1'b0, 1'b1, 8'h1C);
        kd_at("t5_ext_a_unmapped", 8'hFD, 7'h7E);
        sweep();

        // 6: reset during APPLY with rst_req active
        drive(1'b1, 1'b0, 8'h07);
        wait_rst(1'b1, 10, "t6_rst_rise");
        row_sel = 8'h00;
        drive(1'b1, 1'b0, 8'h29);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("t6_kd_cleared", 32'(kd), 32'h7F);
        chk("t6_rst_req_abort", 32'(rst_req), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        busy_seq("t6_no_event", 0, 4);
        sweep();
        send(1'b1, 1'b0, 8'h1A);
        kd_at("t6_z_after_reset", 8'hFB, 7'h7E);
        sweep();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
